// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the fetch/data memory arbiter:
// FSM states, owner tags and memsize codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [2:0] MEMSIZE_BYTE = 3'd0;
  localparam logic [2:0] MEMSIZE_HALF = 3'd1;
  localparam logic [2:0] MEMSIZE_WORD = 3'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side bundle of the arbiter.
// master = arbiter view, slave = requesters plus memory.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic [31:0] if_rdata;
  logic        if_valid;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_size;
  logic [31:0] dm_rdata;
  logic        dm_done;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req,
    input  if_addr,
    input  if_kill,
    output if_rdata,
    output if_valid,
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    input  dm_size,
    output dm_rdata,
    output dm_done,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_size,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    output if_req,
    output if_addr,
    output if_kill,
    input  if_rdata,
    input  if_valid,
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    output dm_size,
    input  dm_rdata,
    input  dm_done,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_size,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data beats fetch, one
// transaction in flight, killed fetches complete silently.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);

  state_t state;
  owner_t owner;
  logic   drop;
  logic   kill_hit;
  logic   drop_now;
  logic   resp;

  assign kill_hit = bus.if_kill
                 && owner == OWN_I
                 && (state == REQ || state == WAIT);

  // a kill coinciding with the response still suppresses it
  assign drop_now = drop || kill_hit;

  assign resp = bus.mem_rvalid
             && (state == WAIT
             || (state == REQ && bus.mem_gnt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= OWN_I;
      drop          <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_size  <= '0;
      bus.if_valid  <= 1'b0;
      bus.dm_done   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.dm_done  <= 1'b0;

      unique case (state)
        IDLE: begin
          drop <= 1'b0;
          if (bus.dm_req) begin
            owner         <= OWN_D;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            bus.mem_size  <= bus.dm_size;
            bus.mem_req   <= 1'b1;
            state         <= REQ;
          end else if (bus.if_req) begin
            owner        <= OWN_I;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.if_addr;
            bus.mem_size <= MEMSIZE_WORD;
            bus.mem_req  <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (kill_hit)
            drop <= 1'b1;
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            state       <= resp ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (kill_hit)
            drop <= 1'b1;
          if (resp)
            state <= DONE;
        end
        DONE: begin
          drop  <= 1'b0;
          state <= IDLE;
        end
      endcase

      if (resp) begin
        if (owner == OWN_D) begin
          bus.dm_done <= 1'b1;
          if (!bus.mem_we)
            bus.dm_rdata <= bus.mem_rdata;
        end else if (!drop_now) begin
          bus.if_valid <= 1'b1;
          bus.if_rdata <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus corner
// sequences, done pulses checked against a scoreboard.
module tb_mem_arbiter;

  localparam logic [1:0] K_IF = 2'd0;
  localparam logic [1:0] K_RD = 2'd1;
  localparam logic [1:0] K_WR = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    int          gd;
    int          rd;
    int          kill_k;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  typedef struct {
    logic        is_fetch;
    int          cyc;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  vec_t vecs[5];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check(string name,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.if_kill    = 1'b0;
    bus.dm_req     = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.dm_size    = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.if_valid || bus.dm_done) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse",
              32'({bus.if_valid, bus.dm_done}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind",
              32'({bus.if_valid, bus.dm_done}),
              e.is_fetch ? 32'd2 : 32'd1);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("if_rdata", bus.if_rdata, e.exp_if);
        check("dm_rdata", bus.dm_rdata, e.exp_dm);
      end
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_mem_size"}, 32'(bus.mem_size), 32'd0);
    check({tag, "_if_valid"}, 32'(bus.if_valid), 32'd0);
    check({tag, "_dm_done"}, 32'(bus.dm_done), 32'd0);
    check({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    check({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    bit seen;
    start = cyc;
    seen = 1'b0;
    bus.if_req   = (v.kind == K_IF);
    bus.if_addr  = v.addr;
    bus.dm_req   = (v.kind != K_IF);
    bus.dm_we    = (v.kind == K_WR);
    bus.dm_addr  = v.addr;
    bus.dm_wdata = v.wdata;
    bus.dm_size  = v.size;
    sb.push_back('{v.kind == K_IF, start + v.lat,
                   v.exp_if, v.exp_dm});
    for (int k = 1; k <= 20 && !seen; k++) begin
      step();
      if (bus.if_valid || bus.dm_done) begin
        seen = 1'b1;
        idle_inputs();
      end else begin
        if (k <= 1 + v.gd) begin
          check("req_held", 32'(bus.mem_req), 32'd1);
          check("req_addr", bus.mem_addr, v.addr);
        end
        if (k == 1) begin
          check("req_we", 32'(bus.mem_we),
                32'(v.kind == K_WR));
          check("req_size", 32'(bus.mem_size),
                32'(v.size));
          if (v.kind == K_WR)
            check("req_wdata", bus.mem_wdata, v.wdata);
        end
        bus.if_kill    = (k == v.kill_k);
        bus.mem_gnt    = (k == 1 + v.gd);
        bus.mem_rvalid = (k == 1 + v.gd + v.rd);
        bus.mem_rdata  = bus.mem_rvalid ? v.rdata
                                        : ~v.rdata;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      idle_inputs();
    end
    step();
    check("back_idle", 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{K_IF, 32'h100, 32'h0, 3'd2, 0, 1, 0,
                32'h00500093, 3, 32'h00500093, 32'h0};
    vecs[1] = '{K_RD, 32'h2000, 32'h0, 3'd2, 0, 0, 0,
                32'h11223344, 2, 32'h00500093,
                32'h11223344};
    vecs[2] = '{K_WR, 32'h2004, 32'hCAFEF00D, 3'd1,
                2, 1, 0, 32'hBAD0BAD0, 5,
                32'h00500093, 32'h11223344};
    vecs[3] = '{K_IF, 32'h104, 32'h0, 3'd2, 1, 2, 0,
                32'h00a00113, 5, 32'h00a00113,
                32'h11223344};
    vecs[4] = '{K_RD, 32'h2003, 32'h0, 3'd0, 0, 3, 2,
                32'h000000AB, 5, 32'h00a00113,
                32'h000000AB};

    reset = 1'b0;
    idle_inputs();
    step();
    step();
    check_zero("reset");
    reset = 1'b1;
    step();

    foreach (vecs[i])
      run_vec(vecs[i]);

    // data write and fetch raised together
    sb.push_back('{1'b0, cyc + 3, 32'h00a00113,
                   32'h000000AB});
    sb.push_back('{1'b1, cyc + 7, 32'h00c00193,
                   32'h000000AB});
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h104;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h2000;
    bus.dm_wdata = 32'hDEADBEEF;
    bus.dm_size  = 3'd2;
    step();
    check("sim_we", 32'(bus.mem_we), 32'd1);
    check("sim_addr", bus.mem_addr, 32'h2000);
    check("sim_wdata", bus.mem_wdata, 32'hDEADBEEF);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55555555;
    step();
    check("sim_dm_done", 32'(bus.dm_done), 32'd1);
    bus.mem_rvalid = 1'b0;
    bus.dm_req     = 1'b0;
    step();
    check("sim_idle_req", 32'(bus.mem_req), 32'd0);
    step();
    check("sim_f_req", 32'(bus.mem_req), 32'd1);
    check("sim_f_addr", bus.mem_addr, 32'h104);
    check("sim_f_we", 32'(bus.mem_we), 32'd0);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00c00193;
    step();
    check("sim_if_valid", 32'(bus.if_valid), 32'd1);
    idle_inputs();
    step();

    // fetch killed while waiting for the response
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h108;
    step();
    check("kill_addr", bus.mem_addr, 32'h108);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    bus.if_kill = 1'b1;
    bus.if_req  = 1'b0;
    step();
    bus.if_kill    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h12345678;
    step();
    check("kill_valid", 32'(bus.if_valid), 32'd0);
    check("kill_rdata", bus.if_rdata, 32'h00c00193);
    idle_inputs();
    step();
    check("kill_idle", 32'(bus.mem_req), 32'd0);

    run_vec('{K_IF, 32'h10C, 32'h0, 3'd2, 0, 1, 0,
              32'h00000013, 3, 32'h00000013,
              32'h000000AB});

    // memory stalls the grant; kill must not drop req
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h200;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("stall_req", 32'(bus.mem_req), 32'd1);
      check("stall_addr", bus.mem_addr, 32'h200);
      bus.if_kill = (k == 3);
    end
    step();
    check("stall_req6", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h77777777;
    step();
    check("stall_valid", 32'(bus.if_valid), 32'd0);
    check("stall_rdata", bus.if_rdata, 32'h00000013);
    idle_inputs();
    step();

    // reset lands in WAIT; late response is ignored
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h3000;
    bus.dm_size = 3'd2;
    step();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    check_zero("rst_wait");
    step();
    step();
    reset = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h99999999;
    step();
    bus.mem_rvalid = 1'b0;
    check("late_done", 32'(bus.dm_done), 32'd0);
    check("late_req", 32'(bus.mem_req), 32'd0);
    step();
    check("late_done2", 32'(bus.dm_done), 32'd0);
    check("late_rdata", bus.dm_rdata, 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
